// File: rtl/layer_feed_pkg.sv
// Shared types and helpers for the layer feedback sequencer.
// No logic of its own; imported by the top-level sequencer.
// Holds the FSM state encoding, the default feedback select and field indexing.
package layer_feed_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FEED = 2'd2
    } state_t;

    // Select value routing accumulator feedback (a_in_1) into a MAC.
    localparam logic [2:0] FEED_SEL_DEFAULT = 3'b001;

    // Low bit of MAC k's select field inside valid_ctrl.
    function automatic int field_lo(input int k, input int sel_w);
        return k * sel_w;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Increment/clear/hold counter that wraps to zero after MAX.
// Latency: one cycle from clr/inc to the new count.
// No handshake; the caller qualifies inc with its own acceptance condition.
module wrap_counter #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= (cnt == W'(MAX)) ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/layer_feed_seq.sv
// Steps accumulator-feedback selects across MAC groups, layer by layer.
// Latency: start -> WAIT next cycle; layer_ready -> first beat next cycle.
// Backpressure: out_ready low freezes state, grp_idx and valid_ctrl.
module layer_feed_seq
    import layer_feed_pkg::*;
#(
    parameter int               N_MAC        = 4,
    parameter int               SEL_W        = 3,
    parameter int               MACS_PER_GRP = 2,
    parameter logic [SEL_W-1:0] FEED_SEL     = SEL_W'(FEED_SEL_DEFAULT),
    parameter int               LAYER_W      = 4,
    localparam int N_GROUP = (N_MAC / MACS_PER_GRP < 1) ? 1 : N_MAC / MACS_PER_GRP,
    localparam int GRP_W   = (N_GROUP > 1) ? $clog2(N_GROUP) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [LAYER_W-1:0]     num_layers,
    input  logic                   layer_ready,
    input  logic                   out_ready,
    output logic [N_MAC*SEL_W-1:0] valid_ctrl,
    output logic [GRP_W-1:0]       grp_idx,
    output logic [LAYER_W-1:0]     layer_idx,
    output logic                   layer_done,
    output logic                   done,
    output logic                   busy
);

    state_t             state_q;
    state_t             state_d;
    logic [LAYER_W-1:0] num_lat;
    logic               last_grp;
    logic               last_layer;
    logic               grp_inc;
    logic               grp_clr;
    logic               lay_inc;
    logic               lay_clr;
    logic               latch_num;
    logic               finish;

    assign last_grp   = (grp_idx == GRP_W'(N_GROUP - 1));
    // Compare against the latched count so a full-scale count never wraps.
    assign last_layer = (layer_idx == num_lat - LAYER_W'(1));

    always_comb begin
        state_d   = state_q;
        grp_inc   = 1'b0;
        grp_clr   = 1'b0;
        lay_inc   = 1'b0;
        lay_clr   = 1'b0;
        latch_num = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    grp_clr = 1'b1;
                    lay_clr = 1'b1;
                    if (num_layers != '0) begin
                        state_d   = WAIT;
                        latch_num = 1'b1;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (layer_ready) begin
                    state_d = FEED;
                end
            end
            FEED: begin
                if (out_ready) begin
                    if (!last_grp) begin
                        grp_inc = 1'b1;
                    end else begin
                        grp_clr = 1'b1;
                        if (last_layer) begin
                            state_d = IDLE;
                            finish  = 1'b1;
                        end else begin
                            lay_inc = 1'b1;
                            state_d = WAIT;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            num_lat <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            done    <= finish;
            if (latch_num) begin
                num_lat <= num_layers;
            end
        end
    end

    wrap_counter #(
        .W   (GRP_W),
        .MAX (N_GROUP - 1)
    ) u_grp_cnt (
        .clk (clk),
        .rst (rst),
        .clr (grp_clr),
        .inc (grp_inc),
        .cnt (grp_idx)
    );

    wrap_counter #(
        .W   (LAYER_W),
        .MAX ((1 << LAYER_W) - 1)
    ) u_layer_cnt (
        .clk (clk),
        .rst (rst),
        .clr (lay_clr),
        .inc (lay_inc),
        .cnt (layer_idx)
    );

    // A beat caught by reset is dropped, so it must not report acceptance.
    assign layer_done = (state_q == FEED) && out_ready && last_grp && !rst;

    always_comb begin
        valid_ctrl = '0;
        if (state_q == FEED) begin
            for (int k = 0; k < N_MAC; k++) begin
                if ((k / MACS_PER_GRP) == int'(grp_idx)) begin
                    valid_ctrl[field_lo(k, SEL_W) +: SEL_W] = FEED_SEL;
                end
            end
        end
    end

endmodule

// File: tb/tb_layer_feed_seq.sv
// Self-checking bench: vector table, hand-written corner sequences, random vs. model.
module tb_layer_feed_seq;

    localparam int NG   = 2;
    localparam int MPG  = 2;
    localparam int SELW = 3;
    localparam logic [2:0] FSEL = 3'b001;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  num_layers;
    logic        layer_ready;
    logic        out_ready;

    logic [11:0] valid_ctrl;
    logic [0:0]  grp_idx;
    logic [3:0]  layer_idx;
    logic        layer_done;
    logic        done;
    logic        busy;

    logic [23:0] valid_ctrl8;
    logic [1:0]  grp_idx8;
    logic [3:0]  layer_idx8;
    logic        layer_done8;
    logic        done8;
    logic        busy8;

    int checks;
    int failures;

    layer_feed_seq dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_layers  (num_layers),
        .layer_ready (layer_ready),
        .out_ready   (out_ready),
        .valid_ctrl  (valid_ctrl),
        .grp_idx     (grp_idx),
        .layer_idx   (layer_idx),
        .layer_done  (layer_done),
        .done        (done),
        .busy        (busy)
    );

    layer_feed_seq #(
        .N_MAC        (8),
        .MACS_PER_GRP (2)
    ) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_layers  (num_layers),
        .layer_ready (layer_ready),
        .out_ready   (out_ready),
        .valid_ctrl  (valid_ctrl8),
        .grp_idx     (grp_idx8),
        .layer_idx   (layer_idx8),
        .layer_done  (layer_done8),
        .done        (done8),
        .busy        (busy8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        start;
        logic [3:0]  nl;
        logic        lr;
        logic        ordy;
        logic [11:0] vc;
        logic        grp;
        logic [3:0]  lay;
        logic        ld;
        logic        dn;
        logic        bsy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic s, input logic [3:0] nl, input logic lr,
                                input logic ordy, input logic [11:0] vc, input logic grp,
                                input logic [3:0] lay, input logic ld, input logic dn,
                                input logic bsy);
        vec_t v;
        v.start = s;  v.nl  = nl;  v.lr = lr;  v.ordy = ordy;
        v.vc    = vc; v.grp = grp; v.lay = lay; v.ld = ld; v.dn = dn; v.bsy = bsy;
        return v;
    endfunction

    // Expected select word: a block of MPG feedback fields shifted to group g.
    function automatic logic [31:0] exp_vc(input int g);
        logic [31:0] blk;
        blk = '0;
        for (int j = 0; j < MPG; j++) begin
            blk = blk | (32'(FSEL) << (SELW * j));
        end
        return blk << (SELW * MPG * g);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; num_layers = '0; layer_ready = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: run position counted in beats over the whole run.
    bit m_run, m_wait, m_done;
    int m_pos, m_n;

    task automatic model_step();
        bit dn;
        dn = 1'b0;
        if (!m_run) begin
            if (start) begin
                if (num_layers == 0) dn = 1'b1;
                else begin
                    m_run = 1'b1; m_wait = 1'b1; m_pos = 0; m_n = int'(num_layers);
                end
            end
        end else if (m_wait) begin
            if (layer_ready) m_wait = 1'b0;
        end else if (out_ready) begin
            m_pos++;
            if (m_pos == m_n * NG) begin
                m_run = 1'b0;
                dn    = 1'b1;
            end else if (m_pos % NG == 0) begin
                m_wait = 1'b1;
            end
        end
        m_done = dn;
    endtask

    int  since;
    int  nld;
    int  ndone;
    bit  ld_seen;
    int  r;

    initial begin
        checks   = 0;
        failures = 0;
        do_reset();

        @(negedge clk);
        chk("reset valid_ctrl", 32'(valid_ctrl), 32'h0);
        chk("reset grp_idx", 32'(grp_idx), 32'h0);
        chk("reset layer_idx", 32'(layer_idx), 32'h0);
        chk("reset layer_done", 32'(layer_done), 32'h0);
        chk("reset done", 32'(done), 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        next_cycle();

        // single layer
        tbl.push_back(mk(1, 1, 1, 1, 12'h000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 12'h000, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 12'h009, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 12'h240, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 12'h000, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 12'h000, 0, 0, 0, 0, 0));
        // backpressure during group 1
        tbl.push_back(mk(1, 1, 1, 1, 12'h000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 1, 12'h000, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 12'h009, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 12'h240, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 12'h240, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 12'h240, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 12'h240, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 1, 12'h000, 0, 0, 0, 1, 0));
        // zero layers
        tbl.push_back(mk(1, 0, 1, 1, 12'h000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 12'h000, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 12'h000, 0, 0, 0, 0, 0));
        // two layers, ignored starts and num_layers churn, restart in done cycle
        tbl.push_back(mk(1, 2, 0, 1, 12'h000, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 0, 1, 12'h000, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 7, 1, 1, 12'h000, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 9, 1, 1, 12'h009, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 12'h240, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 12'h000, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 12'h000, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 12'h009, 0, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 12'h240, 1, 1, 1, 0, 1));
        tbl.push_back(mk(1, 1, 1, 1, 12'h000, 0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 1, 12'h000, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 12'h009, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 12'h240, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 12'h000, 0, 0, 0, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].start; num_layers = tbl[i].nl;
            layer_ready = tbl[i].lr; out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("vec%0d valid_ctrl", i), 32'(valid_ctrl), 32'(tbl[i].vc));
            chk($sformatf("vec%0d grp_idx", i), 32'(grp_idx), 32'(tbl[i].grp));
            chk($sformatf("vec%0d layer_idx", i), 32'(layer_idx), 32'(tbl[i].lay));
            chk($sformatf("vec%0d layer_done", i), 32'(layer_done), 32'(tbl[i].ld));
            chk($sformatf("vec%0d done", i), 32'(done), 32'(tbl[i].dn));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].bsy));
            next_cycle();
        end

        // three layers, layer_ready held off for 5 cycles per layer
        do_reset();
        start = 1'b1; num_layers = 4'd3; layer_ready = 1'b0; out_ready = 1'b1;
        next_cycle();
        start = 1'b0; num_layers = 4'd0;
        since = 0; nld = 0; ndone = 0;
        for (int c = 0; c < 60; c++) begin
            layer_ready = (since >= 5);
            @(negedge clk);
            ld_seen = layer_done;
            if (busy && since <= 5) chk("3L wait valid_ctrl", 32'(valid_ctrl), 32'h0);
            if (layer_done) begin
                chk("3L layer_idx", 32'(layer_idx), 32'(nld));
                nld++;
            end
            if (done) begin
                ndone++;
                chk("3L busy at done", 32'(busy), 32'h0);
            end
            next_cycle();
            since = ld_seen ? 0 : since + 1;
        end
        chk("3L layer_done count", 32'(nld), 32'd3);
        chk("3L done count", 32'(ndone), 32'd1);

        // reset during a FEED beat
        do_reset();
        start = 1'b1; num_layers = 4'd3; layer_ready = 1'b1; out_ready = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("rstfeed beat in flight", 32'(valid_ctrl), 32'h009);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("rstfeed valid_ctrl", 32'(valid_ctrl), 32'h0);
        chk("rstfeed grp_idx", 32'(grp_idx), 32'h0);
        chk("rstfeed layer_idx", 32'(layer_idx), 32'h0);
        chk("rstfeed layer_done", 32'(layer_done), 32'h0);
        chk("rstfeed busy", 32'(busy), 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("rstfeed no done", 32'(done), 32'h0);
            chk("rstfeed stays idle", 32'(busy), 32'h0);
            next_cycle();
        end

        // eight MACs, four groups
        do_reset();
        start = 1'b1; num_layers = 4'd1; layer_ready = 1'b1; out_ready = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            chk($sformatf("n8 beat%0d valid_ctrl", g), 32'(valid_ctrl8), exp_vc(g));
            chk($sformatf("n8 beat%0d grp_idx", g), 32'(grp_idx8), 32'(g));
            chk($sformatf("n8 beat%0d layer_done", g), 32'(layer_done8), 32'(g == 3));
            next_cycle();
        end
        @(negedge clk);
        chk("n8 done", 32'(done8), 32'h1);
        chk("n8 busy low", 32'(busy8), 32'h0);
        next_cycle();

        do_reset();
        start = 1'b1; num_layers = 4'd2; layer_ready = 1'b1; out_ready = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("n8 rst beat in flight", 32'(valid_ctrl8), exp_vc(1));
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("n8 rst valid_ctrl", 32'(valid_ctrl8), 32'h0);
        chk("n8 rst grp_idx", 32'(grp_idx8), 32'h0);
        chk("n8 rst busy", 32'(busy8), 32'h0);
        chk("n8 rst done", 32'(done8), 32'h0);
        next_cycle();

        // randomized run against the model, opening with a full-scale layer count
        do_reset();
        m_run = 1'b0; m_wait = 1'b0; m_done = 1'b0; m_pos = 0; m_n = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 0) begin
                start = 1'b1; num_layers = 4'd15;
            end else begin
                start = ($urandom_range(0, 7) == 0);
                r = int'($urandom_range(0, 15));
                num_layers = (r == 15) ? 4'd15 : 4'(r % 4);
            end
            layer_ready = ($urandom_range(0, 2) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            chk("rnd busy", 32'(busy), 32'(m_run));
            chk("rnd done", 32'(done), 32'(m_done));
            chk("rnd valid_ctrl", 32'(valid_ctrl),
                (m_run && !m_wait) ? exp_vc(m_pos % NG) : 32'h0);
            chk("rnd layer_done", 32'(layer_done),
                32'(m_run && !m_wait && out_ready && (m_pos % NG == NG - 1)));
            if (m_run) begin
                chk("rnd grp_idx", 32'(grp_idx), 32'(m_pos % NG));
                chk("rnd layer_idx", 32'(layer_idx), 32'(m_pos / NG));
            end
            @(posedge clk);
            model_step();
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
